// File: rtl/multicycle_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the RV32 core.
// It drives the datapath enables and memory handshakes, counts retired instructions and traps on faults.
module multicycle_ctrl #(
    parameter int unsigned TO_W        = 8,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    input  logic [15:0] ctrl_sig,
    input  logic        branch_taken,
    output logic        imem_req,
    input  logic        imem_ack,
    output logic        dmem_req,
    output logic        dmem_we,
    input  logic        dmem_ack,
    output logic        ir_we,
    output logic        pc_we,
    output logic [1:0]  pc_sel,
    output logic        rf_we,
    output logic [1:0]  wb_sel,
    output logic        alu_a_sel,
    output logic        alu_b_sel,
    output logic [2:0]  state_o,
    output logic        trap,
    output logic [1:0]  trap_cause,
    output logic [31:0] instret
);

    typedef enum logic [2:0] {
        StFetch  = 3'd0,
        StDecode = 3'd1,
        StExec   = 3'd2,
        StMem    = 3'd3,
        StWb     = 3'd4,
        StTrap   = 3'd7
    } state_e;

    typedef enum logic [2:0] {
        ClsAlu, ClsLoad, ClsStore, ClsBr, ClsJal, ClsJalr, ClsLui, ClsAuipc
    } cls_e;

    localparam logic [TO_W-1:0] ToLast = TO_W'(TIMEOUT_CYC - 1);
    localparam logic [TO_W-1:0] ToOne  = TO_W'(1);

    state_e            state_q;
    cls_e              cls_q;
    cls_e              cls_dec;
    logic              imm_q;
    logic [31:0]       instret_q;
    logic [1:0]        cause_q;
    logic [TO_W-1:0]   to_q;

    logic unused_ctrl;
    assign unused_ctrl = ^ctrl_sig[15:10];

    always_comb begin
        cls_dec = ClsAlu;
        if      (ctrl_sig[3]) cls_dec = ClsLoad;
        else if (ctrl_sig[4]) cls_dec = ClsStore;
        else if (ctrl_sig[5]) cls_dec = ClsBr;
        else if (ctrl_sig[7]) cls_dec = ClsJal;
        else if (ctrl_sig[6]) cls_dec = ClsJalr;
        else if (ctrl_sig[9]) cls_dec = ClsLui;
        else if (ctrl_sig[8]) cls_dec = ClsAuipc;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StFetch;
            cls_q     <= ClsAlu;
            imm_q     <= 1'b0;
            instret_q <= '0;
            cause_q   <= 2'b00;
            to_q      <= '0;
        end else begin
            unique case (state_q)
                StFetch: begin
                    if (run) begin
                        if (imem_ack) begin
                            state_q <= StDecode;
                        end else if (to_q == ToLast) begin
                            state_q <= StTrap;
                            cause_q <= 2'b10;
                        end else begin
                            to_q <= to_q + ToOne;
                        end
                    end
                end
                StDecode: begin
                    cls_q <= cls_dec;
                    imm_q <= ctrl_sig[1];
                    if (ctrl_sig[9:0] == 10'd0) begin
                        state_q <= StTrap;
                        cause_q <= 2'b01;
                    end else begin
                        state_q <= StExec;
                    end
                end
                StExec: begin
                    if (cls_q == ClsBr) begin
                        state_q   <= StFetch;
                        instret_q <= instret_q + 32'd1;
                        to_q      <= '0;
                    end else if (cls_q == ClsLoad || cls_q == ClsStore) begin
                        state_q <= StMem;
                        to_q    <= '0;
                    end else begin
                        state_q <= StWb;
                    end
                end
                StMem: begin
                    // An ack on the expiry cycle takes precedence over the timeout.
                    if (dmem_ack) begin
                        if (cls_q == ClsStore) begin
                            state_q   <= StFetch;
                            instret_q <= instret_q + 32'd1;
                            to_q      <= '0;
                        end else begin
                            state_q <= StWb;
                        end
                    end else if (to_q == ToLast) begin
                        state_q <= StTrap;
                        cause_q <= 2'b11;
                    end else begin
                        to_q <= to_q + ToOne;
                    end
                end
                StWb: begin
                    state_q   <= StFetch;
                    instret_q <= instret_q + 32'd1;
                    to_q      <= '0;
                end
                StTrap: begin
                end
                default: state_q <= StTrap;
            endcase
        end
    end

    // Operand selects stay valid through MEM/WB so the ALU result is stable when consumed.
    logic a_sel_cls;
    logic b_sel_cls;
    assign a_sel_cls = (cls_q == ClsAuipc);
    assign b_sel_cls = (cls_q != ClsBr) &&
                       (imm_q || cls_q == ClsLoad || cls_q == ClsStore ||
                        cls_q == ClsAuipc || cls_q == ClsJalr);

    always_comb begin
        imem_req  = 1'b0;
        ir_we     = 1'b0;
        dmem_req  = 1'b0;
        dmem_we   = 1'b0;
        pc_we     = 1'b0;
        pc_sel    = 2'b00;
        rf_we     = 1'b0;
        wb_sel    = 2'b00;
        alu_a_sel = 1'b0;
        alu_b_sel = 1'b0;
        unique case (state_q)
            StFetch: begin
                imem_req = run;
                ir_we    = run & imem_ack;
            end
            StExec: begin
                alu_a_sel = a_sel_cls;
                alu_b_sel = b_sel_cls;
                if (cls_q == ClsBr) begin
                    pc_we  = 1'b1;
                    pc_sel = branch_taken ? 2'b01 : 2'b00;
                end
            end
            StMem: begin
                alu_a_sel = a_sel_cls;
                alu_b_sel = b_sel_cls;
                dmem_req  = 1'b1;
                dmem_we   = (cls_q == ClsStore);
                pc_we     = dmem_ack && (cls_q == ClsStore);
            end
            StWb: begin
                alu_a_sel = a_sel_cls;
                alu_b_sel = b_sel_cls;
                rf_we     = 1'b1;
                pc_we     = 1'b1;
                if (cls_q == ClsLoad)                          wb_sel = 2'b01;
                else if (cls_q == ClsJal || cls_q == ClsJalr)  wb_sel = 2'b10;
                else if (cls_q == ClsLui)                      wb_sel = 2'b11;
                if (cls_q == ClsJal)                           pc_sel = 2'b01;
                else if (cls_q == ClsJalr)                     pc_sel = 2'b10;
            end
            default: begin
            end
        endcase
    end

    assign state_o    = state_q;
    assign trap       = (state_q == StTrap);
    assign trap_cause = cause_q;
    assign instret    = instret_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl with a 4-cycle memory timeout.
// Inputs change just after the falling edge; outputs are checked 1 ns later.
module tb_multicycle_ctrl;

    logic        clk;
    logic        rst_n;
    logic        run;
    logic [15:0] ctrl_sig;
    logic        branch_taken;
    logic        imem_req;
    logic        imem_ack;
    logic        dmem_req;
    logic        dmem_we;
    logic        dmem_ack;
    logic        ir_we;
    logic        pc_we;
    logic [1:0]  pc_sel;
    logic        rf_we;
    logic [1:0]  wb_sel;
    logic        alu_a_sel;
    logic        alu_b_sel;
    logic [2:0]  state_o;
    logic        trap;
    logic [1:0]  trap_cause;
    logic [31:0] instret;

    int n_assert = 0;
    int n_fail   = 0;

    multicycle_ctrl #(
        .TO_W        (8),
        .TIMEOUT_CYC (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .run          (run),
        .ctrl_sig     (ctrl_sig),
        .branch_taken (branch_taken),
        .imem_req     (imem_req),
        .imem_ack     (imem_ack),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .dmem_ack     (dmem_ack),
        .ir_we        (ir_we),
        .pc_we        (pc_we),
        .pc_sel       (pc_sel),
        .rf_we        (rf_we),
        .wb_sel       (wb_sel),
        .alu_a_sel    (alu_a_sel),
        .alu_b_sel    (alu_b_sel),
        .state_o      (state_o),
        .trap         (trap),
        .trap_cause   (trap_cause),
        .instret      (instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {imem_req, ir_we, dmem_req, dmem_we, pc_we, pc_sel, rf_we, wb_sel, alu_a, alu_b, trap}
    logic [12:0] ctl_obs;
    assign ctl_obs = {imem_req, ir_we, dmem_req, dmem_we, pc_we, pc_sel, rf_we, wb_sel,
                      alu_a_sel, alu_b_sel, trap};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_ctl(input string tag, input logic [2:0] st, input logic [12:0] ctl);
        chk({tag, "/state"}, {29'd0, state_o}, {29'd0, st});
        chk({tag, "/ctl"}, {19'd0, ctl_obs}, {19'd0, ctl});
    endtask

    task automatic cyc(input logic r, input logic iack, input logic dack, input logic bt);
        @(negedge clk);
        run          = r;
        imem_ack     = iack;
        dmem_ack     = dack;
        branch_taken = bt;
        #1;
    endtask

    task automatic fetch_decode(input string tag, input logic [15:0] cs);
        ctrl_sig = cs;
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        check_ctl({tag, "-F"}, 3'd0, 13'b1_1_0_0_0_00_0_00_0_0_0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        check_ctl({tag, "-D"}, 3'd1, 13'b0);
    endtask

    task automatic simple(input string tag, input logic [15:0] cs,
                          input logic [12:0] e_ctl, input logic [12:0] w_ctl);
        fetch_decode(tag, cs);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        check_ctl({tag, "-E"}, 3'd2, e_ctl);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        check_ctl({tag, "-W"}, 3'd4, w_ctl);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        run   = 1'b0;
        #1;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n        = 1'b0;
        run          = 1'b0;
        ctrl_sig     = 16'h0000;
        branch_taken = 1'b0;
        imem_ack     = 1'b0;
        dmem_ack     = 1'b0;
        #2;
        check_ctl("reset", 3'd0, 13'b0);
        chk("reset/instret", instret, 32'd0);
        chk("reset/cause", {30'd0, trap_cause}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Acks with requests low must be ignored.
        cyc(1'b0, 1'b1, 1'b1, 1'b0);
        check_ctl("idle_ack", 3'd0, 13'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        check_ctl("idle_hold", 3'd0, 13'b0);

        simple("addi", 16'h0003, 13'b0_0_0_0_0_00_0_00_0_1_0, 13'b0_0_0_0_1_00_1_00_0_1_0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        check_ctl("addi-done", 3'd0, 13'b0);
        chk("addi/instret", instret, 32'd1);

        // LW with the ack on the third MEM cycle: 7 cycles in total.
        fetch_decode("lw", 16'h000A);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        check_ctl("lw-E", 3'd2, 13'b0_0_0_0_0_00_0_00_0_1_0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        check_ctl("lw-M1", 3'd3, 13'b0_0_1_0_0_00_0_00_0_1_0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        check_ctl("lw-M2", 3'd3, 13'b0_0_1_0_0_00_0_00_0_1_0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        check_ctl("lw-M3", 3'd3, 13'b0_0_1_0_0_00_0_00_0_1_0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        check_ctl("lw-W", 3'd4, 13'b0_0_0_0_1_00_1_01_0_1_0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk("lw/instret", instret, 32'd2);

        fetch_decode("beq_t", 16'h0020);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        check_ctl("beq_t-E", 3'd2, 13'b0_0_0_0_1_01_0_00_0_0_0);
        fetch_decode("beq_n", 16'h0020);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        check_ctl("beq_n-E", 3'd2, 13'b0_0_0_0_1_00_0_00_0_0_0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk("beq/instret", instret, 32'd4);

        // SW whose ack lands on the same cycle the timeout expires.
        fetch_decode("sw", 16'h0012);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        check_ctl("sw-E", 3'd2, 13'b0_0_0_0_0_00_0_00_0_1_0);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b0, 1'b0, 1'b0);
            check_ctl("sw-Mwait", 3'd3, 13'b0_0_1_1_0_00_0_00_0_1_0);
        end
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        check_ctl("sw-Mack", 3'd3, 13'b0_0_1_1_1_00_0_00_0_1_0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        check_ctl("sw-done", 3'd0, 13'b0);
        chk("sw/instret", instret, 32'd5);

        simple("jal", 16'h0080, 13'b0, 13'b0_0_0_0_1_01_1_10_0_0_0);
        simple("jalr", 16'h0042, 13'b0_0_0_0_0_00_0_00_0_1_0, 13'b0_0_0_0_1_10_1_10_0_1_0);
        simple("lui", 16'h0200, 13'b0, 13'b0_0_0_0_1_00_1_11_0_0_0);
        simple("auipc", 16'h0100, 13'b0_0_0_0_0_00_0_00_1_1_0, 13'b0_0_0_0_1_00_1_00_1_1_0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk("mix/instret", instret, 32'd9);

        // Retire count wraps from all-ones to zero.
        force dut.instret_q = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut.instret_q;
        #1;
        chk("wrap/pre", instret, 32'hFFFF_FFFF);
        simple("wrap", 16'h0001, 13'b0, 13'b0_0_0_0_1_00_1_00_0_0_0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk("wrap/instret", instret, 32'd0);

        // Reset in MEM drops the data request without waiting for a clock.
        fetch_decode("rstmem", 16'h0012);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk("rstmem/req_before", {31'd0, dmem_req}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rstmem/req_after", {31'd0, dmem_req}, 32'd0);
        chk("rstmem/state", {29'd0, state_o}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Illegal class vector traps and holds off further fetches.
        fetch_decode("ill", 16'h0000);
        for (int i = 0; i < 10; i++) begin
            cyc(1'b1, i[0], 1'b0, 1'b0);
            check_ctl("ill-trap", 3'd7, 13'b0_0_0_0_0_00_0_00_0_0_1);
        end
        chk("ill/cause", {30'd0, trap_cause}, 32'd1);
        chk("ill/instret", instret, 32'd0);

        do_reset();
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 1'b0, 1'b0, 1'b0);
            check_ctl("ito-wait", 3'd0, 13'b1_0_0_0_0_00_0_00_0_0_0);
        end
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        check_ctl("ito-trap", 3'd7, 13'b0_0_0_0_0_00_0_00_0_0_1);
        chk("ito/cause", {30'd0, trap_cause}, 32'd2);

        do_reset();
        fetch_decode("dto", 16'h0012);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 1'b0, 1'b0, 1'b0);
            check_ctl("dto-wait", 3'd3, 13'b0_0_1_1_0_00_0_00_0_1_0);
        end
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        check_ctl("dto-trap", 3'd7, 13'b0_0_0_0_0_00_0_00_0_0_1);
        chk("dto/cause", {30'd0, trap_cause}, 32'd3);
        chk("dto/instret", instret, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
